alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencer for the H4 ALU block. It accepts one ALU operation at a time from the instruction decoder over a valid/ready handshake and drives the H4 control lines (x, y, z, v, Sa, Sb, u) for one or more cycles. It then captures carry/overflow and arbitrates for the shared S-bus before asserting ALS_H4 for exactly one cycle. It sits between the decoder and H4_module and is the only source of ALS_H4.

## Interface
Parameters:
- REP_W, 4, width of the repeat count
- BUS_TMO, 15, maximum cycles to wait for bus_gnt before aborting the bus phase

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- CLR  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_func  in  4  ALU function, driven as {x,y,z,v}
- req_sa, req_sb  in  1 each  selector controls for the first ALU cycle
- req_cin  in  1  carry-in for the first ALU cycle
- req_rep  in  REP_W  number of additional chained ALU cycles (0 = single cycle)
- req_nobus  in  1  skip the S-bus phase (flags only)
- x, y, z, v, Sa, Sb, u  out  1 each  H4 control lines
- ALS_H4  out  1  H4 to S-bus enable
- bus_req  out  1  S-bus request to the bus arbiter
- bus_gnt  in  1  S-bus grant
- carry, overflow  in  1 each  status from H4_module
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- flag_c, flag_v  out  1 each  captured carry/overflow
- err  out  1  bus timeout occurred on the last operation

## Operation
- States: IDLE, ALU, CAPT, BREQ, DRIVE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch all req_* fields, load rep counter with req_rep, clear flag_c/flag_v/err, go to ALU.
- ALU:
  - First cycle: {x,y,z,v}=func, Sa=req_sa, Sb=req_sb, u=req_cin.
  - Later cycles: func and Sb held, Sa=1 (feedback of previous result), u=0.
  - Counter decrements each cycle; when the counter is 0, go to CAPT.
  - Total ALU cycles = req_rep+1 (req_rep=15 gives 16 cycles, with no wrap).
- CAPT:
  - All H4 controls 0.
  - Sample carry→flag_c and overflow→flag_v at the end of this cycle.
  - Next state is DONE if nobus, else BREQ.
- BREQ:
  - bus_req=1.
  - If bus_gnt=1 in this cycle, go to DRIVE.
  - Otherwise the wait counter increments. After BUS_TMO cycles with no grant: set err=1, go to DONE; ALS_H4 is never asserted.
- DRIVE:
  - ALS_H4=1 and bus_req=1 for exactly one cycle.
  - bus_gnt is ignored in this state.
  - Go to DONE.
- DONE: done=1, then go to IDLE.
- flag_c, flag_v and err hold until the next accepted request.
- Only one request is in flight; req_ready=0 in every state except IDLE, so no back-to-back acceptance in DONE.

## Timing
- Cycle 0 is the handshake cycle.
  - ALU occupies cycles 1..1+rep; CAPT is cycle 2+rep.
  - With req_nobus=1, done is high in cycle 3+rep.
  - With the bus phase and grant in the first BREQ cycle: BREQ at 3+rep, DRIVE at 4+rep, done at 5+rep, req_ready at 6+rep.
- Each grant-wait cycle adds one cycle. A timeout gives done at cycle 3+rep+BUS_TMO with err=1.
- Reset (CLR=0 sampled at an edge):
  - Next state is IDLE, counters cleared.
  - x, y, z, v, Sa, Sb, u, ALS_H4, bus_req, busy, done, flag_c, flag_v and err are all 0.
  - req_ready is forced 0 while CLR=0.
  - Reset in the middle of an operation abandons it with no done pulse. If reset lands in DRIVE, ALS_H4 drops in the next cycle.
- All outputs are registered or decoded from state only. No combinational path from req_valid or bus_gnt to any output.

## Structure
- Package alu_seq_pkg holds:
  - the state enum,
  - the default REP_W and BUS_TMO values,
  - a packed request struct (func, sa, sb, cin, rep, nobus).
- Sub-module alu_seq_bus_timer: a wait counter with clear/enable inputs and a timeout output, parameterised by BUS_TMO.
- The top level contains the FSM, the request latch, the repeat counter and the flag registers.

## Test plan
- func=4'b1010, sa=0, sb=1, cin=1, rep=0, nobus=0, bus_gnt tied 1 → control lines 1,0,1,0/0/1/1 in cycle 1; ALS_H4 only in cycle 4; done in cycle 5; flags equal to carry/overflow in cycle 2.
- rep=3, cin=1, sa=0 → 4 ALU cycles; cycle 1 has Sa=0, u=1; cycles 2–4 have Sa=1, u=0; done in cycle 8.
- bus_gnt held 0, BUS_TMO=15 → bus_req high for 15 cycles, ALS_H4 never 1, done with err=1 in cycle 18 (rep=0), then req_ready=1.
- nobus=1 with carry=1, overflow=0 during CAPT → done in cycle 3, flag_c=1, flag_v=0, bus_req never asserted.
- CLR=0 sampled while in DRIVE → next cycle ALS_H4=0, bus_req=0, no done pulse, all flags 0; req_ready=1 on the first cycle after CLR returns high.
- req_valid held high during an operation → only one acceptance; the second request is accepted in the IDLE cycle after done.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the H4 ALU sequencer.
package alu_seq_pkg;

    localparam int DEF_REP_W   = 4;
    localparam int DEF_BUS_TMO = 15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALU   = 3'd1,
        S_CAPT  = 3'd2,
        S_BREQ  = 3'd3,
        S_DRIVE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Latched copy of a decoder request; rep doubles as the live repeat counter.
    typedef struct packed {
        logic [3:0]           func;
        logic                 sa;
        logic                 sb;
        logic                 cin;
        logic [DEF_REP_W-1:0] rep;
        logic                 nobus;
    } req_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Decoder handshake and S-bus arbitration signals of the ALU sequencer.
// The master side is the environment (decoder plus bus arbiter); the
// slave side is the sequencer itself.
interface alu_seq_ctrl_if #(
    parameter int REP_W = alu_seq_pkg::DEF_REP_W
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_func;
    logic             req_sa;
    logic             req_sb;
    logic             req_cin;
    logic [REP_W-1:0] req_rep;
    logic             req_nobus;
    logic             bus_req;
    logic             bus_gnt;

    modport master (
        output req_valid, req_func, req_sa, req_sb, req_cin, req_rep, req_nobus, bus_gnt,
        input  req_ready, bus_req
    );

    modport slave (
        input  req_valid, req_func, req_sa, req_sb, req_cin, req_rep, req_nobus, bus_gnt,
        output req_ready, bus_req
    );
endinterface

// File: rtl/alu_seq_bus_timer.sv
// Grant-wait counter: counts enabled cycles and flags the last permitted one.
module alu_seq_bus_timer #(
    parameter int BUS_TMO = alu_seq_pkg::DEF_BUS_TMO
) (
    input  logic CLK,
    input  logic CLR,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);
    localparam int CW = $clog2(BUS_TMO + 1);

    logic [CW-1:0] r_cnt;

    // Count waiting cycles; a sync clear restarts the wait window.
    always_ff @(posedge CLK) begin
        if (!CLR || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // High in the BUS_TMO-th enabled cycle, i.e. the last one allowed to see a grant.
    assign o_timeout = i_en && (r_cnt == CW'(BUS_TMO - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// H4 ALU sequencer: accepts one operation, steps the H4 control lines for
// rep+1 cycles, captures carry/overflow, then optionally arbitrates for
// the S-bus and pulses ALS_H4 for a single cycle.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int REP_W   = DEF_REP_W,
    parameter int BUS_TMO = DEF_BUS_TMO
) (
    input  logic           CLK,
    input  logic           CLR,
    alu_seq_ctrl_if.slave  bus,
    output logic           x,
    output logic           y,
    output logic           z,
    output logic           v,
    output logic           Sa,
    output logic           Sb,
    output logic           u,
    output logic           ALS_H4,
    input  logic           carry,
    input  logic           overflow,
    output logic           busy,
    output logic           done,
    output logic           flag_c,
    output logic           flag_v,
    output logic           err
);

    // The request struct carries the repeat counter at the package width.
    if (REP_W != DEF_REP_W) begin : g_rep_w_chk
        $error("alu_seq_ctrl: REP_W must equal DEF_REP_W");
    end

    state_t r_state;
    state_t w_state_next;
    req_t   r_req;
    req_t   w_req_in;
    logic   r_first;
    logic   r_flag_c;
    logic   r_flag_v;
    logic   r_err;
    logic   w_accept;
    logic   w_tmo;
    logic   w_in_breq;

    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_in_breq = (r_state == S_BREQ);

    alu_seq_bus_timer #(
        .BUS_TMO (BUS_TMO)
    ) u_bus_timer (
        .CLK       (CLK),
        .CLR       (CLR),
        .i_clr     (!w_in_breq),
        .i_en      (w_in_breq),
        .o_timeout (w_tmo)
    );

    // Pack the incoming request fields for the latch.
    always_comb begin
        w_req_in = '{
            func:  bus.req_func,
            sa:    bus.req_sa,
            sb:    bus.req_sb,
            cin:   bus.req_cin,
            rep:   bus.req_rep,
            nobus: bus.req_nobus
        };
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a grant in the final wait cycle still wins over timeout.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_ALU;
            S_ALU:   if (r_req.rep == '0) w_state_next = S_CAPT;
            S_CAPT:  w_state_next = r_req.nobus ? S_DONE : S_BREQ;
            S_BREQ: begin
                if (bus.bus_gnt) begin
                    w_state_next = S_DRIVE;
                end else if (w_tmo) begin
                    w_state_next = S_DONE;
                end
            end
            S_DRIVE: w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state and latched request only.
    always_comb begin
        {x, y, z, v}  = 4'b0000;
        Sa            = 1'b0;
        Sb            = 1'b0;
        u             = 1'b0;
        ALS_H4        = 1'b0;
        bus.bus_req   = 1'b0;
        bus.req_ready = 1'b0;
        done          = 1'b0;
        busy          = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE:  bus.req_ready = CLR;
            S_ALU: begin
                {x, y, z, v} = r_req.func;
                // After the first cycle the A selector feeds back the previous result.
                Sa           = r_first ? r_req.sa : 1'b1;
                Sb           = r_req.sb;
                u            = r_first & r_req.cin;
            end
            S_BREQ:  bus.bus_req = 1'b1;
            S_DRIVE: begin
                ALS_H4      = 1'b1;
                bus.bus_req = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Request latch, repeat counter and status flags.
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            r_req    <= '0;
            r_first  <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req    <= w_req_in;
                        r_first  <= 1'b1;
                        r_flag_c <= 1'b0;
                        r_flag_v <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                S_ALU: begin
                    r_first <= 1'b0;
                    if (r_req.rep != '0) begin
                        r_req.rep <= r_req.rep - 1'b1;
                    end
                end
                S_CAPT: begin
                    r_flag_c <= carry;
                    r_flag_v <= overflow;
                end
                S_BREQ: begin
                    if (!bus.bus_gnt && w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign flag_c = r_flag_c;
    assign flag_v = r_flag_v;
    assign err    = r_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: directed scenarios plus random operations,
// each checked cycle by cycle against an expected timeline.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int REP_W   = DEF_REP_W;
    localparam int BUS_TMO = DEF_BUS_TMO;

    logic CLK = 1'b0;
    logic CLR;
    logic x, y, z, v, Sa, Sb, u, ALS_H4;
    logic carry, overflow;
    logic busy, done, flag_c, flag_v, err;

    int n_checks = 0;
    int n_errors = 0;
    int n_ops    = 0;
    logic prev_c, prev_v, prev_e;

    alu_seq_ctrl_if #(.REP_W(REP_W)) bus_if ();

    alu_seq_ctrl #(
        .REP_W   (REP_W),
        .BUS_TMO (BUS_TMO)
    ) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .bus      (bus_if),
        .x        (x),
        .y        (y),
        .z        (z),
        .v        (v),
        .Sa       (Sa),
        .Sb       (Sb),
        .u        (u),
        .ALS_H4   (ALS_H4),
        .carry    (carry),
        .overflow (overflow),
        .busy     (busy),
        .done     (done),
        .flag_c   (flag_c),
        .flag_v   (flag_v),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all outputs of the current cycle against expectations.
    // hs = {ALS_H4, bus_req, busy, done, req_ready}; fl = {flag_c, flag_v, err}
    task automatic check_cycle(input string tag, input logic [6:0] e_ctrl,
                               input logic [4:0] e_hs, input logic [2:0] e_fl);
        check({tag, " ctrl"}, 16'({x, y, z, v, Sa, Sb, u}), 16'(e_ctrl));
        check({tag, " hs"}, 16'({ALS_H4, bus_if.bus_req, busy, done, bus_if.req_ready}), 16'(e_hs));
        check({tag, " flags"}, 16'({flag_c, flag_v, err}), 16'(e_fl));
    endtask

    // One operation from handshake (cycle 0) to its done cycle. g is the number
    // of grant-less bus-wait cycles before the grant (>= BUS_TMO means none).
    // cv_fix >= 0 forces {carry,overflow} during capture; rst_at >= 0 pulls CLR
    // low in that cycle and abandons the operation.
    task automatic run_op(input logic [3:0] func, input logic sa, input logic sb,
                          input logic cin, input int rep, input logic nobus,
                          input int g, input logic hold, input int cv_fix,
                          input int rst_at);
        int capt, done_c, breq_lo, breq_hi, drv;
        logic exp_c, exp_v, exp_e;
        logic [6:0] e_ctrl;
        logic [4:0] e_hs;
        logic [2:0] e_fl;
        string tag;

        capt    = rep + 2;
        breq_lo = rep + 3;
        breq_hi = -1;
        drv     = -1;
        exp_c   = 1'b0;
        exp_v   = 1'b0;
        exp_e   = 1'b0;
        if (nobus) begin
            done_c = rep + 3;
        end else if (g < BUS_TMO) begin
            breq_hi = rep + 3 + g;
            drv     = rep + 4 + g;
            done_c  = rep + 5 + g;
        end else begin
            breq_hi = rep + 2 + BUS_TMO;
            done_c  = rep + 3 + BUS_TMO;
            exp_e   = 1'b1;
        end
        n_ops++;

        for (int k = 0; k <= done_c; k++) begin
            @(posedge CLK);
            #1;
            CLR                 = (k != rst_at);
            bus_if.req_valid    = (k == 0) || hold;
            bus_if.req_func     = func;
            bus_if.req_sa       = sa;
            bus_if.req_sb       = sb;
            bus_if.req_cin      = cin;
            bus_if.req_rep      = rep[REP_W-1:0];
            bus_if.req_nobus    = nobus;
            if (k >= breq_lo && k <= breq_hi) begin
                bus_if.bus_gnt = (k == rep + 3 + g);
            end else begin
                bus_if.bus_gnt = 1'($urandom_range(0, 1));
            end
            if (k == capt && cv_fix >= 0) begin
                {carry, overflow} = cv_fix[1:0];
            end else begin
                {carry, overflow} = 2'($urandom_range(0, 3));
            end
            if (k == capt) begin
                exp_c = carry;
                exp_v = overflow;
            end

            @(negedge CLK);
            e_ctrl = (k >= 1 && k <= rep + 1) ?
                     {func, (k == 1) ? sa : 1'b1, sb, (k == 1) ? cin : 1'b0} : 7'b0;
            e_hs   = {k == drv, (k >= breq_lo && k <= breq_hi) || k == drv,
                      k >= 1, k == done_c, k == 0};
            if (k == 0) begin
                e_fl = {prev_c, prev_v, prev_e};
            end else if (k <= capt) begin
                e_fl = 3'b000;
            end else begin
                e_fl = {exp_c, exp_v, (k == done_c) ? exp_e : 1'b0};
            end
            tag = $sformatf("op%0d c%0d", n_ops, k);
            check_cycle(tag, e_ctrl, e_hs, e_fl);
            if (k == rst_at) break;
        end

        if (rst_at >= 0) begin
            // Still in reset: everything low, including req_ready.
            @(posedge CLK);
            #1;
            CLR              = 1'b0;
            bus_if.req_valid = 1'b0;
            @(negedge CLK);
            check_cycle($sformatf("op%0d rst", n_ops), 7'b0, 5'b00000, 3'b000);
            // First cycle out of reset: idle and ready.
            @(posedge CLK);
            #1;
            CLR = 1'b1;
            @(negedge CLK);
            check_cycle($sformatf("op%0d post-rst", n_ops), 7'b0, 5'b00001, 3'b000);
            prev_c = 1'b0;
            prev_v = 1'b0;
            prev_e = 1'b0;
            $display("op %0d: func=%b rep=%0d reset at cycle %0d", n_ops, func, rep, rst_at);
        end else begin
            prev_c = exp_c;
            prev_v = exp_v;
            prev_e = exp_e;
            $display("op %0d: func=%b sa=%b sb=%b cin=%b rep=%0d nobus=%b wait=%0d hold=%b done@%0d c=%b v=%b err=%b",
                     n_ops, func, sa, sb, cin, rep, nobus, g, hold, done_c, exp_c, exp_v, exp_e);
        end
    endtask

    initial begin
        CLR              = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_func  = 4'b0;
        bus_if.req_sa    = 1'b0;
        bus_if.req_sb    = 1'b0;
        bus_if.req_cin   = 1'b0;
        bus_if.req_rep   = '0;
        bus_if.req_nobus = 1'b0;
        bus_if.bus_gnt   = 1'b0;
        carry            = 1'b0;
        overflow         = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_cycle("reset", 7'b0, 5'b00000, 3'b000);
        @(posedge CLK);
        #1;
        CLR = 1'b1;
        @(negedge CLK);
        check_cycle("reset release", 7'b0, 5'b00001, 3'b000);
        prev_c = 1'b0;
        prev_v = 1'b0;
        prev_e = 1'b0;

        // Basic bus operation, immediate grant.
        run_op(4'b1010, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0, -1, -1);
        // Chained ALU cycles.
        run_op(4'b0110, 1'b0, 1'b0, 1'b1, 3, 1'b0, 0, 1'b0, -1, -1);
        // Grant never arrives: timeout.
        run_op(4'b1111, 1'b1, 1'b1, 1'b0, 0, 1'b0, BUS_TMO, 1'b0, -1, -1);
        // Flags only, carry=1 overflow=0 at capture.
        run_op(4'b0011, 1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 1'b0, 2, -1);
        // Reset while driving the bus (DRIVE is cycle 4 for rep=0, no wait).
        run_op(4'b1100, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, -1, 4);
        // req_valid held high through the operation, then a new request.
        run_op(4'b0101, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1, 1'b1, -1, -1);
        run_op(4'b1001, 1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0, -1, -1);
        // Maximum repeat, grant in the last permitted wait cycle.
        run_op(4'b1001, 1'b0, 1'b0, 1'b0, 15, 1'b0, BUS_TMO - 1, 1'b0, -1, -1);

        for (int i = 0; i < 40; i++) begin
            int g;
            if ($urandom_range(0, 3) == 0) begin
                g = int'($urandom_range(BUS_TMO - 1, BUS_TMO + 2));
            end else begin
                g = int'($urandom_range(0, 4));
            end
            run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   g, 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
